// File: rtl/btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl
//
// Sequences every write into the branch target buffer. Branch resolutions
// from EX are queued in a small FIFO and applied one at a time as a
// read-modify-write (IDLE -> RD -> WR, three cycles per update) under a
// strong/valid hysteresis policy. A flush request runs a sweep that writes
// zero to every BTB entry, one entry per cycle.
//
// Handshake: EX offers a resolution with ex_br_vld and there is no ready.
// A resolution is accepted when the queue is not full, or when it is full
// but the head is popped in the same cycle. Otherwise it is dropped and
// drop_cnt counts it. Dropping is harmless because the BTB is only a hint.
//
// BTB read timing: btb_raddr is registered on the IDLE->RD edge, and the BTB
// must present btb_rdata for that address during the RD cycle. A write
// issued in WR has landed before the next RD, so no forwarding is needed.
//
// Entry format: {1'b0, TAG[24:18], S[17], V[16], TGT[15:0]}.
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   ex_br_vld    EX resolved a branch this cycle
//   ex_br_pc     PC of the resolved branch
//   ex_br_taken  branch resolved taken
//   ex_br_tgt    resolved target
//   flush_req    one-cycle pulse: invalidate the whole BTB
//   btb_raddr    BTB read index
//   btb_rdata    BTB read data for btb_raddr, valid in RD
//   btb_we       BTB write enable (only in WR or FLUSH)
//   btb_waddr    BTB write index
//   btb_wdata    BTB write data, bit 25 always 0
//   busy         FSM not IDLE or queue non-empty
//   fifo_full    resolution queue full
//   drop_cnt     saturating count of dropped resolutions
//   dbg_state    current FSM state (0 IDLE, 1 RD, 2 WR, 3 FLUSH)
// ---------------------------------------------------------------------------
module btb_update_ctrl #(
    parameter int IDX_W      = 9,
    parameter int TAG_W      = 7,
    parameter int PC_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_br_vld,
    input  logic [PC_W-1:0]         ex_br_pc,
    input  logic                    ex_br_taken,
    input  logic [PC_W-1:0]         ex_br_tgt,
    input  logic                    flush_req,
    output logic [IDX_W-1:0]        btb_raddr,
    input  logic [TAG_W+PC_W+2:0]   btb_rdata,
    output logic                    btb_we,
    output logic [IDX_W-1:0]        btb_waddr,
    output logic [TAG_W+PC_W+2:0]   btb_wdata,
    output logic                    busy,
    output logic                    fifo_full,
    output logic [7:0]              drop_cnt,
    output logic [1:0]              dbg_state
);

    localparam int ENT_W = TAG_W + PC_W + 3;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_flush_pend;
    logic                r_we;
    logic [IDX_W-1:0]    r_raddr;
    logic [IDX_W-1:0]    r_waddr;
    logic [ENT_W-1:0]    r_wdata;
    logic [7:0]          r_drop;

    // Resolution being processed, captured at pop.
    logic [PC_W-1:0]     r_cur_pc;
    logic                r_cur_taken;
    logic [PC_W-1:0]     r_cur_tgt;

    // Resolution queue
    logic [PC_W-1:0]     r_fifo_pc    [FIFO_DEPTH];
    logic                r_fifo_taken [FIFO_DEPTH];
    logic [PC_W-1:0]     r_fifo_tgt   [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W:0]      r_count;

    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    logic [TAG_W-1:0]    w_tag_in;
    logic [TAG_W-1:0]    w_old_tag;
    logic                w_old_s;
    logic                w_old_v;
    logic [PC_W-1:0]     w_old_tgt;
    logic                w_hit;
    logic                w_need_wr;
    logic [ENT_W-1:0]    w_new;
    logic                w_unused;

    // A pop only happens from IDLE with no flush pending, so the flush wins.
    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = (r_state == S_IDLE) && !r_flush_pend && (r_count != '0);
    assign w_push = ex_br_vld && (!w_full || w_pop);
    assign w_drop = ex_br_vld && !w_push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wptr]    <= ex_br_pc;
                r_fifo_taken[r_wptr] <= ex_br_taken;
                r_fifo_tgt[r_wptr]   <= ex_br_tgt;
                r_wptr               <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    // Entry fields returned by the BTB during RD.
    assign w_tag_in  = r_cur_pc[PC_W-1:IDX_W];
    assign w_old_tag = btb_rdata[ENT_W-2 -: TAG_W];
    assign w_old_s   = btb_rdata[PC_W+1];
    assign w_old_v   = btb_rdata[PC_W];
    assign w_old_tgt = btb_rdata[PC_W-1:0];
    assign w_hit     = w_old_v && (w_old_tag == w_tag_in);
    // Bit 25 of a read entry carries no information.
    assign w_unused  = btb_rdata[ENT_W-1];

    // Hysteresis policy: a strong entry owned by another branch is only
    // weakened on a miss, so it takes two misses to replace it.
    always_comb begin
        w_need_wr = 1'b0;
        w_new     = '0;
        if (r_cur_taken) begin
            w_need_wr = 1'b1;
            if (w_hit) begin
                w_new = {1'b0, w_tag_in, 1'b1, 1'b1, r_cur_tgt};
            end else if (w_old_v && w_old_s) begin
                w_new = {1'b0, w_old_tag, 1'b0, 1'b1, w_old_tgt};
            end else begin
                w_new = {1'b0, w_tag_in, 1'b0, 1'b1, r_cur_tgt};
            end
        end else if (w_hit) begin
            w_need_wr = 1'b1;
            if (w_old_s) begin
                w_new = {1'b0, w_old_tag, 1'b0, 1'b1, w_old_tgt};
            end else begin
                w_new = {1'b0, w_old_tag, 1'b0, 1'b0, w_old_tgt};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_flush_pend <= 1'b0;
            r_we         <= 1'b0;
            r_raddr      <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_cur_pc     <= '0;
            r_cur_taken  <= 1'b0;
            r_cur_tgt    <= '0;
        end else begin
            // A request arriving during a sweep is absorbed by that sweep.
            if (flush_req && (r_state != S_FLUSH)) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (r_flush_pend) begin
                        r_we    <= 1'b1;
                        r_waddr <= '0;
                        r_wdata <= '0;
                        r_state <= S_FLUSH;
                    end else if (r_count != '0) begin
                        r_raddr     <= r_fifo_pc[r_rptr][IDX_W-1:0];
                        r_cur_pc    <= r_fifo_pc[r_rptr];
                        r_cur_taken <= r_fifo_taken[r_rptr];
                        r_cur_tgt   <= r_fifo_tgt[r_rptr];
                        r_state     <= S_RD;
                    end
                end
                S_RD: begin
                    r_we    <= w_need_wr;
                    r_waddr <= r_cur_pc[IDX_W-1:0];
                    r_wdata <= w_new;
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    r_wdata <= '0;
                    if (&r_waddr) begin
                        r_we         <= 1'b0;
                        r_flush_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_waddr <= r_waddr + 1'b1;
                    end
                end
                default: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign btb_raddr = r_raddr;
    assign btb_we    = r_we;
    assign btb_waddr = r_waddr;
    assign btb_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_full = w_full;
    assign drop_cnt  = r_drop;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btb_update_ctrl
//
// Directed bench for btb_update_ctrl. A behavioural BTB (512 x 26) answers
// reads for btb_raddr within the cycle and commits writes on posedge. Every
// write the controller issues is logged as {waddr, wdata} and compared with
// an expected queue built from hand-derived entries.
// ---------------------------------------------------------------------------
module tb_btb_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_br_vld;
    logic [15:0] ex_br_pc;
    logic        ex_br_taken;
    logic [15:0] ex_br_tgt;
    logic        flush_req;
    logic [8:0]  btb_raddr;
    logic [25:0] btb_rdata;
    logic        btb_we;
    logic [8:0]  btb_waddr;
    logic [25:0] btb_wdata;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_cnt;
    logic [1:0]  dbg_state;

    int n_tests;
    int n_fail;

    logic [25:0] mem [512];
    logic [34:0] wr_q  [$];
    logic [34:0] exp_q [$];

    btb_update_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_br_vld  (ex_br_vld),
        .ex_br_pc   (ex_br_pc),
        .ex_br_taken(ex_br_taken),
        .ex_br_tgt  (ex_br_tgt),
        .flush_req  (flush_req),
        .btb_raddr  (btb_raddr),
        .btb_rdata  (btb_rdata),
        .btb_we     (btb_we),
        .btb_waddr  (btb_waddr),
        .btb_wdata  (btb_wdata),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BTB model and write log ----------------
    assign btb_rdata = mem[btb_raddr];

    always @(posedge clk) begin
        if (btb_we) begin
            mem[btb_waddr] <= btb_wdata;
            wr_q.push_back({btb_waddr, btb_wdata});
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [25:0] mk(input logic [6:0] tag, input logic s,
                                       input logic v, input logic [15:0] tgt);
        return {1'b0, tag, s, v, tgt};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        ex_br_vld   = 1'b1;
        ex_br_pc    = pc;
        ex_br_taken = taken;
        ex_br_tgt   = tgt;
        tick();
        ex_br_vld   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((busy || dbg_state != 2'd0) && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 64'(n < max_cycles), 64'd1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < wr_q.size()) ? 64'(wr_q[i]) : 64'hDEAD_BEEF_DEAD, 64'(exp_q[i]));
        end
    endtask

    task automatic add_flush_exp();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({9'(i), 26'd0});
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] pcs [6];
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        ex_br_vld   = 1'b0;
        ex_br_pc    = '0;
        ex_br_taken = 1'b0;
        ex_br_tgt   = '0;
        flush_req   = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_we",    64'(btb_we),    64'd0);
        check("rst_raddr", 64'(btb_raddr), 64'd0);
        check("rst_waddr", 64'(btb_waddr), 64'd0);
        check("rst_wdata", 64'(btb_wdata), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_full",  64'(fifo_full), 64'd0);
        check("rst_drop",  64'(drop_cnt),  64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: allocate into an empty BTB, write lands 3 cycles after the push
        push(16'h1234, 1'b1, 16'h2000);
        check("t1_we_c1",   64'(btb_we),    64'd0);
        check("t1_busy",    64'(busy),      64'd1);
        tick();
        check("t1_state_rd", 64'(dbg_state), 64'd1);
        check("t1_raddr",    64'(btb_raddr), 64'h034);
        check("t1_we_c2",    64'(btb_we),    64'd0);
        tick();
        check("t1_we_c3",   64'(btb_we),    64'd1);
        check("t1_waddr",   64'(btb_waddr), 64'h034);
        check("t1_wdata",   64'(btb_wdata), 64'(mk(7'h09, 1'b0, 1'b1, 16'h2000)));
        tick();
        check("t1_we_off",  64'(btb_we),    64'd0);
        check("t1_idle",    64'(dbg_state), 64'd0);
        check("t1_mem",     64'(mem[9'h034]), 64'(mk(7'h09, 1'b0, 1'b1, 16'h2000)));

        // 2: not-taken hits weaken then invalidate
        mem[9'h034] = mk(7'h09, 1'b1, 1'b1, 16'h2000);
        push(16'h1234, 1'b0, 16'h0000);
        wait_idle("t2a_to", 20);
        check("t2_s_clr", 64'(mem[9'h034]), 64'(mk(7'h09, 1'b0, 1'b1, 16'h2000)));
        push(16'h1234, 1'b0, 16'h0000);
        wait_idle("t2b_to", 20);
        check("t2_v_clr", 64'(mem[9'h034]), 64'(mk(7'h09, 1'b0, 1'b0, 16'h2000)));

        // 3: taken miss on a strong foreign entry only weakens it, then allocates
        mem[9'h034] = mk(7'h05, 1'b1, 1'b1, 16'h0100);
        push(16'h1234, 1'b1, 16'h2000);
        wait_idle("t3a_to", 20);
        check("t3_weaken", 64'(mem[9'h034]), 64'(mk(7'h05, 1'b0, 1'b1, 16'h0100)));
        push(16'h1234, 1'b1, 16'h2000);
        wait_idle("t3b_to", 20);
        check("t3_alloc", 64'(mem[9'h034]), 64'(mk(7'h09, 1'b0, 1'b1, 16'h2000)));
        // taken hit promotes to strong
        push(16'h1234, 1'b1, 16'h2222);
        wait_idle("t3c_to", 20);
        check("t3_strong", 64'(mem[9'h034]), 64'(mk(7'h09, 1'b1, 1'b1, 16'h2222)));
        // not-taken miss (tag 0x29, same index) writes nothing
        wr_q.delete();
        push(16'h5234, 1'b0, 16'h0000);
        wait_idle("t3d_to", 20);
        check("t3_nowrite", 64'(wr_q.size()), 64'd0);
        check("t3_keep", 64'(mem[9'h034]), 64'(mk(7'h09, 1'b1, 1'b1, 16'h2222)));

        // 4: six back-to-back pushes while a sweep holds the FSM -> 2 dropped
        wr_q.delete();
        exp_q.delete();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check("t4_flush_st", 64'(dbg_state), 64'd3);
        pcs = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};
        for (int k = 0; k < 6; k++) begin
            push(pcs[k], 1'b1, 16'hA000 + 16'(k));
            if (k == 3) check("t4_full", 64'(fifo_full), 64'd1);
        end
        check("t4_drop", 64'(drop_cnt), 64'd2);
        add_flush_exp();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({pcs[k][8:0], mk(pcs[k][15:9], 1'b0, 1'b1, 16'hA000 + 16'(k))});
        end
        wait_idle("t4_to", 800);
        compare_log("t4_log");
        check("t4_notfull", 64'(fifo_full), 64'd0);
        check("t4_drop_hold", 64'(drop_cnt), 64'd2);

        // 5: flush during RD -> the RMW write completes, then the full sweep
        wr_q.delete();
        exp_q.delete();
        push(16'h1234, 1'b1, 16'h2000);
        tick();
        check("t5_rd", 64'(dbg_state), 64'd1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("t5_wr", 64'(dbg_state), 64'd2);
        check("t5_we", 64'(btb_we), 64'd1);
        tick();
        check("t5_idle_gap_we", 64'(btb_we), 64'd0);
        tick();
        check("t5_flush_st", 64'(dbg_state), 64'd3);
        exp_q.push_back({9'h034, mk(7'h09, 1'b0, 1'b1, 16'h2000)});
        add_flush_exp();
        wait_idle("t5_to", 800);
        compare_log("t5_log");
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_we_end", 64'(btb_we), 64'd0);

        // 6: reset in the middle of a sweep at idx 100 stops writes at once
        wr_q.delete();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        begin
            int n;
            n = 0;
            while (!(dbg_state == 2'd3 && btb_waddr == 9'd100) && n < 200) begin
                tick();
                n++;
            end
            check("t6_reach_to", 64'(n < 200), 64'd1);
        end
        rst_n = 1'b0;
        tick();
        check("t6_we",    64'(btb_we),    64'd0);
        check("t6_state", 64'(dbg_state), 64'd0);
        check("t6_waddr", 64'(btb_waddr), 64'd0);
        check("t6_nwr",   64'(wr_q.size()), 64'd101);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("t6_nwr_after", 64'(wr_q.size()), 64'd101);
        check("t6_busy",      64'(busy),        64'd0);
        check("t6_mem101",    64'(mem[9'd101]), 64'(mk(7'h09, 1'b0, 1'b1, 16'h2000) & 26'd0) | 64'(mem[9'd101] === 26'd0 ? 26'd0 : 26'h3FFFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
